// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter - round-robin arbiter sharing one single-port data RAM between
// the CPU load/store port (0) and the debug/loader port (1).
module data_ram_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk_25mhz,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  grant_id
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    last_served;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    take;
  logic                    pick;

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // On a conflict the port that was not served last wins, so a pending port
  // waits for at most one foreign transaction.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick      = grant_id;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take      = 1'b1;
          pick      = (req0 && req1) ? ~last_served : req1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      last_served <= 1'b1;
      grant_id    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
    end else begin
      if (take) begin
        grant_id <= pick;
        we_q     <= pick ? we1 : we0;
        addr_q   <= pick ? addr1 : addr0;
        wdata_q  <= pick ? wdata1 : wdata0;
      end
      if (state == ISSUE) begin
        cnt <= CNT_W'(RAM_LATENCY - 1);
      end
      if (state == WAIT) begin
        if (cnt == '0) begin
          if (!we_q) begin
            rdata <= ram_rdata;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      if (state == DONE) begin
        last_served <= grant_id;
      end
    end
  end

  // RAM strobes decode straight from the state so an async reset drops them at once.
  assign ram_en    = (state == ISSUE);
  assign ram_we    = ram_en & we_q;
  assign ram_addr  = ram_en ? addr_q : '0;
  assign ram_wdata = ram_en ? wdata_q : '0;
  assign ack0      = (state == DONE) & ~grant_id;
  assign ack1      = (state == DONE) & grant_id;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter - directed bench with a transaction-timeline reference model
// for data_ram_arbiter at RAM latency 1, plus a latency-3 instance.
module tb_data_ram_arbiter;

  localparam int L1 = 1;
  localparam int L3 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [7:0]  addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, ram_en, ram_we, busy, grant_id;
  logic [31:0] rdata, ram_wdata, ram_rdata;
  logic [7:0]  ram_addr;

  logic        q_req = 0, q_we = 0;
  logic [7:0]  q_addr = 0;
  logic [31:0] q_wdata = 0;
  logic        q_ack0, q_ack1, q_ram_en, q_ram_we, q_busy, q_grant;
  logic [31:0] q_rdata, q_ram_wdata, q_ram_rdata;
  logic [7:0]  q_ram_addr;
  logic        q_zero = 1'b0;
  logic [7:0]  q_zaddr = 8'h00;
  logic [31:0] q_zdata = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RAM_LATENCY(L1)) dut (
    .clk_25mhz(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .grant_id(grant_id));

  data_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RAM_LATENCY(L3)) dut3 (
    .clk_25mhz(clk), .rst_n(rst_n), .req0(q_req), .req1(q_zero), .we0(q_we), .we1(q_zero),
    .addr0(q_addr), .addr1(q_zaddr), .wdata0(q_wdata), .wdata1(q_zdata), .ack0(q_ack0),
    .ack1(q_ack1), .rdata(q_rdata), .ram_en(q_ram_en), .ram_we(q_ram_we),
    .ram_addr(q_ram_addr), .ram_wdata(q_ram_wdata), .ram_rdata(q_ram_rdata),
    .busy(q_busy), .grant_id(q_grant));

  // Bench RAMs: read data appears LATENCY edges after the strobe edge.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] s1_0 = 0, s3_0 = 0, s3_1 = 0, s3_2 = 0;
  assign ram_rdata   = s1_0;
  assign q_ram_rdata = s3_2;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'h0;
      mem3[i] = 32'h0;
    end
    mem3[255] = 32'h0000000F;
  end

  always @(posedge clk) begin
    if (ram_en && ram_we) mem1[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) s1_0 <= mem1[ram_addr];
    if (q_ram_en && q_ram_we) mem3[q_ram_addr] <= q_ram_wdata;
    if (q_ram_en && !q_ram_we) s3_0 <= mem3[q_ram_addr];
    s3_1 <= s3_0;
    s3_2 <= s3_1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a granted transaction occupies cycles t=0..L+1 (strobe at t=0,
  // ack at t=L+1) and is followed by at least one idle cycle.
  logic [31:0] m_mem [256];
  logic        m_active = 0, m_last = 1, m_grant = 0, m_we = 0;
  logic [7:0]  m_addr = 0;
  logic [31:0] m_wdata = 0, m_rdata = 0;
  int          m_t = 0;

  initial for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_t = 0; m_last = 1; m_grant = 0; m_rdata = 0;
      m_we = 0; m_addr = 0; m_wdata = 0;
    end else if (m_active) begin
      if (m_t == L1 + 1) begin
        m_active = 0;
        m_last = m_grant;
      end else begin
        m_t++;
        if (m_t == L1 + 1 && !m_we) m_rdata = m_mem[m_addr];
      end
    end else if (req0 || req1) begin
      m_grant = (req0 && req1) ? !m_last : req1;
      m_we    = m_grant ? we1 : we0;
      m_addr  = m_grant ? addr1 : addr0;
      m_wdata = m_grant ? wdata1 : wdata0;
      if (m_we) m_mem[m_addr] = m_wdata;
      m_active = 1;
      m_t = 0;
    end
  end

  always @(negedge clk) begin
    logic exp_en;
    exp_en = m_active && (m_t == 0);
    check("busy", busy, m_active);
    check("ram_en", ram_en, exp_en);
    check("ram_we", ram_we, exp_en && m_we);
    check("ack0", ack0, m_active && m_t == L1 + 1 && !m_grant);
    check("ack1", ack1, m_active && m_t == L1 + 1 && m_grant);
    check("grant_id", grant_id, m_grant);
    check("rdata", rdata, m_rdata);
    if (exp_en) begin
      check("ram_addr", ram_addr, m_addr);
      check("ram_wdata", ram_wdata, m_wdata);
    end
  end

  int en_cnt = 0, we_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, cyc = 0;
  logic [7:0]  en_addr = 0;
  logic [31:0] en_wdata = 0;
  int en_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (ram_en) begin
      en_cnt++;
      en_addr = ram_addr;
      en_wdata = ram_wdata;
      en_cyc.push_back(cyc);
    end
    if (ram_we) we_cnt++;
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
  end

  task automatic wait_ack(input int port, input int max, output int edges);
    logic got;
    edges = 0;
    got = 0;
    while (!got && edges < max) begin
      @(posedge clk);
      #1;
      edges++;
      got = port ? ack1 : ack0;
    end
    check($sformatf("ack%0d_seen", port), got, 1'b1);
  endtask

  initial begin
    int e;
    int seq[$];
    int idle;
    int a0;
    logic started, got;

    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ack", {ack0, ack1}, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    // 1: single write on port 0
    @(posedge clk); #2;
    req0 = 1; we0 = 1; addr0 = 8'h05; wdata0 = 32'hDEADBEEF;
    wait_ack(0, 20, e);
    check("t1_latency", e, 3);
    req0 = 0;
    check("t1_en_cnt", en_cnt, 1);
    check("t1_we_cnt", we_cnt, 1);
    check("t1_en_addr", en_addr, 8'h05);
    check("t1_en_wdata", en_wdata, 32'hDEADBEEF);
    check("t1_no_ack1", ack1_cnt, 0);

    // 2: readback on port 1
    @(posedge clk); #2;
    req1 = 1; we1 = 0; addr1 = 8'h05;
    wait_ack(1, 20, e);
    check("t2_latency", e, 3);
    check("t2_rdata", rdata, 32'hDEADBEEF);
    req1 = 0;
    check("t2_we_cnt", we_cnt, 1);

    // 3: conflict right after reset
    @(posedge clk); #2 rst_n = 0;
    @(posedge clk); #2 rst_n = 1;
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 32'h0000000A;
    req1 = 1; we1 = 0; addr1 = 8'h05;
    wait_ack(0, 20, e);
    check("t3_first_latency", e, 3);
    check("t3_first_grant", grant_id, 1'b0);
    req0 = 0;
    wait_ack(1, 20, e);
    check("t3_second_latency", e, 4);
    check("t3_second_grant", grant_id, 1'b1);
    check("t3_rdata", rdata, 32'hDEADBEEF);
    check("t3_en_gap", en_cyc[en_cyc.size()-1] - en_cyc[en_cyc.size()-2], 4);
    req1 = 0;

    // 4: both held -> strict alternation, one idle cycle between transactions
    @(posedge clk); #2;
    req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 32'h00000030;
    req1 = 1; we1 = 1; addr1 = 8'h31; wdata1 = 32'h00000031;
    started = 0; idle = 0;
    for (int c = 0; c < 200 && seq.size() < 6; c++) begin
      @(posedge clk); #1;
      if (ram_en) started = 1;
      if (started && !busy) idle++;
      if (ack0 || ack1) seq.push_back(int'(ack1));
    end
    req0 = 0; req1 = 0;
    check("t4_ack_count", seq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      got = (i < seq.size()) ? (seq[i] == (i % 2)) : 1'b0;
      check($sformatf("t4_order%0d", i), got, 1'b1);
    end
    check("t4_idle_cycles", idle, 5);

    // 5: reset during WAIT of a write, then a pending port-1 read
    @(posedge clk); #2;
    req0 = 1; we0 = 1; addr0 = 8'h22; wdata0 = 32'h12345678;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      got = ram_en;
    end
    check("t5_issue_seen", got, 1'b1);
    @(posedge clk); #3;
    check("t5_in_wait", busy, 1'b1);
    a0 = ack0_cnt;
    rst_n = 0;
    #1;
    check("t5_ram_en", ram_en, 1'b0);
    check("t5_ram_we", ram_we, 1'b0);
    check("t5_acks", {ack0, ack1}, 2'b00);
    check("t5_busy", busy, 1'b0);
    req0 = 0;
    req1 = 1; we1 = 0; addr1 = 8'h05;
    @(posedge clk); #2 rst_n = 1;
    wait_ack(1, 20, e);
    check("t5_latency", e, 3);
    check("t5_rdata", rdata, 32'hDEADBEEF);
    check("t5_no_ack0", ack0_cnt, a0);
    req1 = 0;

    // 6: latency-3 read of preloaded word
    @(posedge clk); #2;
    q_req = 1; q_we = 0; q_addr = 8'hFF;
    e = 0; got = 0;
    while (!got && e < 30) begin
      @(posedge clk); #1;
      e++;
      got = q_ack0;
    end
    q_req = 0;
    check("t6_ack_seen", got, 1'b1);
    check("t6_latency", e, 5);
    check("t6_rdata", q_rdata, 32'h0000000F);
    check("t6_no_ack1", q_ack1, 1'b0);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
